// File: rtl/sub_arbiter.sv
// Round-robin arbiter that time-shares one external WIDTH-bit subtractor between
// N_REQ requesters, returning each difference on a single tagged response channel.
module sub_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 64,
   parameter int ID_W  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic [WIDTH-1:0]       sub_a,
   output logic [WIDTH-1:0]       sub_b,
   input  logic [WIDTH-1:0]       sub_result,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [WIDTH-1:0]       rsp_data,
   output logic                   rsp_borrow
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t            state, state_next;
   logic [ID_W-1:0]   rr_ptr, id_q, grant_idx, cand;
   logic              grant_found, accept, complete;
   logic [WIDTH-1:0]  op_a, op_b, sel_a, sel_b;

   // Scan downward so the last hit, i.e. the one closest to rr_ptr, wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = N_REQ-1; k >= 0; k--) begin
         cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
         if (req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_idx == ID_W'(i)) begin
            sel_a = req_a[i*WIDTH +: WIDTH];
            sel_b = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   assign accept   = (state == IDLE) && grant_found;
   assign complete = (state == RESP) && rsp_ready;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = accept && (grant_idx == ID_W'(i));
      end
   end

   assign sub_a = op_a;
   assign sub_b = op_b;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept)   state_next = ISSUE;
         ISSUE:                 state_next = RESP;
         RESP:    if (complete) state_next = IDLE;
         default:               state_next = IDLE;
      endcase
   end

   // The pointer only moves when a response retires, so a stalled response
   // cannot let later requesters overtake the fairness order.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr     <= '0;
         id_q       <= '0;
         op_a       <= '0;
         op_b       <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_data   <= '0;
         rsp_borrow <= 1'b0;
      end else begin
         if (accept) begin
            op_a <= sel_a;
            op_b <= sel_b;
            id_q <= grant_idx;
         end
         if (state == ISSUE) begin
            rsp_data   <= sub_result;
            rsp_borrow <= (op_a < op_b);
            rsp_id     <= id_q;
            rsp_valid  <= 1'b1;
         end
         if (complete) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= ID_W'((int'(id_q) + 1) % N_REQ);
         end
      end
   end

endmodule

// File: tb/tb_sub_arbiter.sv
// Directed self-checking bench for sub_arbiter with four requesters; the shared
// subtractor is modelled as a plain combinational a-b.
module tb_sub_arbiter;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    reqValid;
   logic [3:0]    reqReady;
   logic [255:0]  reqA, reqB;
   logic [63:0]   subA, subB, subResult;
   logic          rspValid, rspReady, rspBorrow;
   logic [1:0]    rspId;
   logic [63:0]   rspData;

   int assertCount = 0;
   int failCount   = 0;

   logic [63:0] aVec [4] = '{64'd100, 64'd200, 64'd300, 64'd10};
   logic [63:0] bVec [4] = '{64'd1,   64'd50,  64'd7,   64'd20};
   logic [63:0] dVec [4] = '{64'd99,  64'd150, 64'd293, 64'hFFFF_FFFF_FFFF_FFF6};
   logic        wVec [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

   sub_arbiter #(.N_REQ(4), .WIDTH(64), .ID_W(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (reqValid),
      .req_ready  (reqReady),
      .req_a      (reqA),
      .req_b      (reqB),
      .sub_a      (subA),
      .sub_b      (subB),
      .sub_result (subResult),
      .rsp_valid  (rspValid),
      .rsp_ready  (rspReady),
      .rsp_id     (rspId),
      .rsp_data   (rspData),
      .rsp_borrow (rspBorrow)
   );

   assign subResult = subA - subB;

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic setReq(input int id, input logic [63:0] a, input logic [63:0] b);
      reqA[id*64 +: 64] = a;
      reqB[id*64 +: 64] = b;
   endtask

   // One complete transaction with the response accepted immediately.
   task automatic applyStimulus(input logic [3:0] mask, input int id, input logic [63:0] a,
                                input logic [63:0] b, input logic [63:0] expData, input logic expBorrow);
      logic [3:0] oh;
      oh = 4'b0001 << id;
      reqValid = mask;
      setReq(id, a, b);
      #1;
      checkOutput("grant", 64'(reqReady), 64'(oh));
      step();
      reqValid = '0;
      setReq(id, ~a, ~b);
      #1;
      checkOutput("issue_ready", 64'(reqReady), 64'd0);
      checkOutput("sub_a", subA, a);
      checkOutput("sub_b", subB, b);
      step();
      checkOutput("rsp_valid", 64'(rspValid), 64'd1);
      checkOutput("rsp_id", 64'(rspId), 64'(id));
      checkOutput("rsp_data", rspData, expData);
      checkOutput("rsp_borrow", 64'(rspBorrow), 64'(expBorrow));
      rspReady = 1'b1;
      step();
      rspReady = 1'b0;
      checkOutput("rsp_retired", 64'(rspValid), 64'd0);
   endtask

   initial begin
      rst      = 1'b1;
      reqValid = '0;
      reqA     = '0;
      reqB     = '0;
      rspReady = 1'b0;
      step();
      step();
      checkOutput("reset_rsp_valid", 64'(rspValid), 64'd0);
      checkOutput("reset_rsp_data", rspData, 64'd0);
      checkOutput("reset_req_ready", 64'(reqReady), 64'd0);
      checkOutput("reset_sub_a", subA, 64'd0);
      rst = 1'b0;
      step();

      applyStimulus(4'b0010, 1, 64'd5, 64'd3, 64'd2, 1'b0);
      applyStimulus(4'b0001, 0, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      applyStimulus(4'b0001, 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 1'b0);

      // Round robin from a freshly reset pointer with everyone requesting.
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) setReq(i, aVec[i], bVec[i]);
      reqValid = 4'b1111;
      rspReady = 1'b1;
      #1;
      for (int n = 0; n < 5; n++) begin
         int id;
         id = n % 4;
         checkOutput("rr_grant", 64'(reqReady), 64'(4'b0001 << id));
         step();
         step();
         checkOutput("rr_rsp_id", 64'(rspId), 64'(id));
         checkOutput("rr_rsp_data", rspData, dVec[id]);
         checkOutput("rr_rsp_borrow", 64'(rspBorrow), 64'(wVec[id]));
         step();
      end

      // Backpressure: the response must hold while requests stay pending.
      rspReady = 1'b0;
      checkOutput("bp_grant", 64'(reqReady), 64'(4'b0010));
      step();
      step();
      for (int c = 0; c < 5; c++) begin
         checkOutput("bp_rsp_valid", 64'(rspValid), 64'd1);
         checkOutput("bp_rsp_id", 64'(rspId), 64'd1);
         checkOutput("bp_rsp_data", rspData, 64'd150);
         checkOutput("bp_req_ready", 64'(reqReady), 64'd0);
         step();
      end
      rspReady = 1'b1;
      step();
      rspReady = 1'b0;
      checkOutput("bp_released", 64'(rspValid), 64'd0);
      checkOutput("bp_next_grant", 64'(reqReady), 64'(4'b0100));
      step();

      // Reset while requester 2 is in ISSUE.
      reqValid = '0;
      rst = 1'b1;
      step();
      checkOutput("mid_rst_rsp_valid", 64'(rspValid), 64'd0);
      checkOutput("mid_rst_rsp_id", 64'(rspId), 64'd0);
      checkOutput("mid_rst_rsp_data", rspData, 64'd0);
      checkOutput("mid_rst_rsp_borrow", 64'(rspBorrow), 64'd0);
      checkOutput("mid_rst_sub_a", subA, 64'd0);
      checkOutput("mid_rst_sub_b", subB, 64'd0);
      checkOutput("mid_rst_req_ready", 64'(reqReady), 64'd0);
      rst = 1'b0;
      step();
      step();
      checkOutput("abandoned_no_rsp", 64'(rspValid), 64'd0);
      applyStimulus(4'b1100, 2, 64'd40, 64'd15, 64'd25, 1'b0);
      applyStimulus(4'b1000, 3, 64'd7, 64'd9, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);

      // Pointer is now 0; requester 2 alone wins, requester 1 appears and leaves while busy.
      setReq(2, 64'd1000, 64'd1);
      reqValid = 4'b0100;
      #1;
      checkOutput("wrap_grant", 64'(reqReady), 64'(4'b0100));
      step();
      reqValid = 4'b0010;
      #1;
      checkOutput("skip_busy_ready", 64'(reqReady), 64'd0);
      step();
      reqValid = 4'b0000;
      checkOutput("wrap_rsp_id", 64'(rspId), 64'd2);
      checkOutput("wrap_rsp_data", rspData, 64'd999);
      rspReady = 1'b1;
      step();
      rspReady = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checkOutput("skip_no_grant", 64'(reqReady), 64'd0);
         checkOutput("skip_no_rsp", 64'(rspValid), 64'd0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
